// File: rtl/din_link_scheduler_pkg.sv
// Shared types and constants for the DIN link scheduler.
// Holds FSM states, MODE codes, frame layout and arbiter helpers.
package din_link_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC0,
    SYNC1,
    FRAME
  } state_e;

  localparam logic [1:0] MODE_A = 2'd0;
  localparam logic [1:0] MODE_B = 2'd1;
  localparam logic [1:0] MODE_C = 2'd2;

  localparam int FRAME_BITS = 10;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [7:0] d
  );
    return {START_BIT, d, STOP_BIT};
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == MODE_C) ? MODE_A : x + 2'd1;
  endfunction

  // first requester at or after ptr, wrapping mod 3
  function automatic logic [1:0] rr_pick(
    input logic [2:0] req,
    input logic [1:0] ptr
  );
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(ptr);
    c2 = inc3(c1);
    if (req[ptr]) return ptr;
    if (req[c1])  return c1;
    return c2;
  endfunction

endpackage

// File: rtl/din_link_scheduler_serializer.sv
// Bit-timing shift register for the DIN line: sync runs and frames.
// Shifts MSB first; fill is the bit shifted in behind the data.
module din_frame_serializer
  import din_link_scheduler_pkg::*;
#(
  parameter int BIT_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_val,
  input  logic                  fill,
  output logic                  sdo,
  output logic                  bit_end,
  output logic [5:0]            bit_cnt,
  output logic                  done
);

  localparam logic [3:0] DIV_LAST = 4'(BIT_DIV - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_val;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (bit_end) begin
      shreg   <= {shreg[FRAME_BITS-2:0], fill};
      div_cnt <= '0;
      bit_cnt <= bit_cnt + 6'd1;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign bit_end = (div_cnt == DIV_LAST);
  assign done    = bit_end && (bit_cnt == 6'(FRAME_BITS - 1));
  assign sdo     = shreg[FRAME_BITS-1];

endmodule

// File: rtl/din_link_scheduler.sv
// Round-robin scheduler sharing the converter DIN line among 3 sources.
// Per grant: sync header, then a burst of start/data/stop frames.
module din_link_scheduler
  import din_link_scheduler_pkg::*;
#(
  parameter int BLOCK_LEN  = 240,
  parameter int SYNC_ZEROS = 10,
  parameter int SYNC_ONES  = 9,
  parameter int BIT_DIV    = 1
) (
  input  logic       CLK_30MHZ,
  input  logic       RSTN,
  input  logic [2:0] REQ,
  input  logic [7:0] DATA_A,
  input  logic [7:0] DATA_B,
  input  logic [7:0] DATA_C,
  output logic [2:0] ACK,
  output logic [2:0] GNT,
  output logic [1:0] MODE,
  output logic       DIN,
  output logic       BUSY
);

  state_e state;
  state_e state_d;

  logic [9:0]            fcnt;
  logic [9:0]            fcnt_d;
  logic [1:0]            ptr;
  logic [1:0]            ptr_d;
  logic [2:0]            gnt_d;
  logic [2:0]            ack_d;
  logic [1:0]            mode_d;
  logic                  busy_d;
  logic                  ld;
  logic [FRAME_BITS-1:0] ld_val;
  logic                  fill;
  logic                  bit_end;
  logic [5:0]            bit_cnt;
  logic                  done;
  logic [7:0]            data_g;
  logic [1:0]            pick;
  logic                  req_g;
  logic                  sync0_end;
  logic                  sync1_end;
  logic                  blk_end;

  din_frame_serializer #(
    .BIT_DIV (BIT_DIV)
  ) u_ser (
    .clk      (CLK_30MHZ),
    .rst_n    (RSTN),
    .load     (ld),
    .load_val (ld_val),
    .fill     (fill),
    .sdo      (DIN),
    .bit_end  (bit_end),
    .bit_cnt  (bit_cnt),
    .done     (done)
  );

  always_comb begin
    data_g = '0;
    unique case (MODE)
      MODE_A:  data_g = DATA_A;
      MODE_B:  data_g = DATA_B;
      MODE_C:  data_g = DATA_C;
      default: data_g = '0;
    endcase
  end

  assign pick      = rr_pick(REQ, ptr);
  assign req_g     = |(REQ & GNT);
  assign fill      = (state == SYNC1);
  assign sync0_end = bit_end && (bit_cnt == 6'(SYNC_ZEROS - 1));
  assign sync1_end = bit_end && (bit_cnt == 6'(SYNC_ONES - 1));
  assign blk_end   = (11'(fcnt) + 11'd1 == 11'(BLOCK_LEN)) || !req_g;

  always_ff @(posedge CLK_30MHZ or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (|REQ)             state_d = SYNC0;
      SYNC0: if (sync0_end)        state_d = SYNC1;
      SYNC1: if (sync1_end)        state_d = FRAME;
      FRAME: if (done && blk_end)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = GNT;
    mode_d = MODE;
    busy_d = BUSY;
    ack_d  = '0;
    fcnt_d = fcnt;
    ptr_d  = ptr;
    ld     = 1'b0;
    ld_val = '0;
    unique case (state)
      IDLE: begin
        if (|REQ) begin
          gnt_d  = 3'(3'b001 << pick);
          mode_d = pick;
          busy_d = 1'b1;
          fcnt_d = '0;
          ld     = 1'b1;
        end
      end
      SYNC0: begin
        if (sync0_end) begin
          ld     = 1'b1;
          ld_val = '1;
        end
      end
      SYNC1: begin
        if (sync1_end) begin
          ld     = 1'b1;
          ld_val = frame_word(data_g);
          ack_d  = GNT;
        end
      end
      FRAME: begin
        if (done && blk_end) begin
          ld     = 1'b1;
          gnt_d  = '0;
          busy_d = 1'b0;
          ptr_d  = inc3(MODE);
        end else if (done) begin
          ld     = 1'b1;
          ld_val = frame_word(data_g);
          ack_d  = GNT;
          fcnt_d = fcnt + 10'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_30MHZ or negedge RSTN) begin
    if (!RSTN) begin
      GNT  <= '0;
      ACK  <= '0;
      MODE <= MODE_A;
      BUSY <= 1'b0;
      fcnt <= '0;
      ptr  <= MODE_A;
    end else begin
      GNT  <= gnt_d;
      ACK  <= ack_d;
      MODE <= mode_d;
      BUSY <= busy_d;
      fcnt <= fcnt_d;
      ptr  <= ptr_d;
    end
  end

endmodule

// File: tb/tb_din_link_scheduler.sv
// Directed bench for din_link_scheduler: four instances with
// different block length / bit divider, checked step by step.
module tb_din_link_scheduler;

  logic       clk;
  logic       rstn;
  logic [2:0] req  [4];
  logic [7:0] da   [4];
  logic [7:0] db   [4];
  logic [7:0] dc   [4];
  logic [2:0] ack  [4];
  logic [2:0] gnt  [4];
  logic [1:0] mode [4];
  logic       din  [4];
  logic       busy [4];

  int nvec;
  int nerr;

  din_link_scheduler #(
    .BLOCK_LEN(2), .SYNC_ZEROS(10), .SYNC_ONES(9), .BIT_DIV(1)
  ) u0 (
    .CLK_30MHZ(clk), .RSTN(rstn), .REQ(req[0]),
    .DATA_A(da[0]), .DATA_B(db[0]), .DATA_C(dc[0]),
    .ACK(ack[0]), .GNT(gnt[0]), .MODE(mode[0]),
    .DIN(din[0]), .BUSY(busy[0])
  );

  din_link_scheduler #(
    .BLOCK_LEN(1), .SYNC_ZEROS(10), .SYNC_ONES(9), .BIT_DIV(1)
  ) u1 (
    .CLK_30MHZ(clk), .RSTN(rstn), .REQ(req[1]),
    .DATA_A(da[1]), .DATA_B(db[1]), .DATA_C(dc[1]),
    .ACK(ack[1]), .GNT(gnt[1]), .MODE(mode[1]),
    .DIN(din[1]), .BUSY(busy[1])
  );

  din_link_scheduler #(
    .BLOCK_LEN(240), .SYNC_ZEROS(10), .SYNC_ONES(9), .BIT_DIV(1)
  ) u2 (
    .CLK_30MHZ(clk), .RSTN(rstn), .REQ(req[2]),
    .DATA_A(da[2]), .DATA_B(db[2]), .DATA_C(dc[2]),
    .ACK(ack[2]), .GNT(gnt[2]), .MODE(mode[2]),
    .DIN(din[2]), .BUSY(busy[2])
  );

  din_link_scheduler #(
    .BLOCK_LEN(1), .SYNC_ZEROS(10), .SYNC_ONES(9), .BIT_DIV(4)
  ) u3 (
    .CLK_30MHZ(clk), .RSTN(rstn), .REQ(req[3]),
    .DATA_A(da[3]), .DATA_B(db[3]), .DATA_C(dc[3]),
    .ACK(ack[3]), .GNT(gnt[3]), .MODE(mode[3]),
    .DIN(din[3]), .BUSY(busy[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int u, input string tag);
    int t = 0;
    while (gnt[u] == 3'b000 && t < 300) begin
      tick();
      t++;
    end
    chk({tag, " grant seen"}, 128'(gnt[u] != 3'b000), 128'd1);
  endtask

  task automatic wait_idle(input int u, input string tag);
    int t = 0;
    while (busy[u] && t < 400) begin
      tick();
      t++;
    end
    chk({tag, " idle seen"}, 128'(busy[u]), 128'd0);
  endtask

  initial begin
    logic [38:0]  got39;
    logic [38:0]  exp39;
    logic [9:0]   w;
    logic [9:0]   f3;
    logic [28:0]  b29;
    logic [115:0] e116;
    logic [115:0] g116;
    logic [19:0]  g20;
    logic [2:0]   eg [4];
    logic [1:0]   em [4];
    logic [2:0]   ack_pre;
    int c;
    int nack;
    int bad;
    int fr;
    int first;

    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req[i] = '0;
      da[i]  = '0;
      db[i]  = '0;
      dc[i]  = '0;
    end

    // reset values
    tick();
    tick();
    tick();
    chk("rst din",  128'(din[0]),  128'd0);
    chk("rst mode", 128'(mode[0]), 128'd0);
    chk("rst ack",  128'(ack[0]),  128'd0);
    chk("rst gnt",  128'(gnt[0]),  128'd0);
    chk("rst busy", 128'(busy[0]), 128'd0);
    rstn = 1'b1;

    // T1: source A, two frames of A5
    da[0]  = 8'hA5;
    req[0] = 3'b001;
    wait_gnt(0, "t1");
    chk("t1 gnt",  128'(gnt[0]),  128'h1);
    chk("t1 mode", 128'(mode[0]), 128'h0);
    chk("t1 busy", 128'(busy[0]), 128'h1);
    got39 = '0;
    nack  = 0;
    for (int k = 0; k < 39; k++) begin
      got39 = {got39[37:0], din[0]};
      if (ack[0][0]) nack++;
      tick();
    end
    exp39 = {10'b0, 9'h1FF, 10'b11010_01010, 10'b11010_01010};
    chk("t1 din stream", 128'(got39), 128'(exp39));
    chk("t1 acks",       128'(nack),  128'd2);
    chk("t1 busy fall",  128'(busy[0]), 128'd0);
    chk("t1 gnt clear",  128'(gnt[0]),  128'd0);
    chk("t1 mode hold",  128'(mode[0]), 128'd0);
    chk("t1 din idle",   128'(din[0]),  128'd0);
    req[0] = 3'b000;

    // T2: all request, one frame per grant, round robin
    eg[0] = 3'b001; eg[1] = 3'b010; eg[2] = 3'b100; eg[3] = 3'b001;
    em[0] = 2'd0;   em[1] = 2'd1;   em[2] = 2'd2;   em[3] = 2'd0;
    req[1] = 3'b111;
    for (int b = 0; b < 4; b++) begin
      wait_gnt(1, $sformatf("t2.%0d", b));
      chk($sformatf("t2.%0d gnt", b),  128'(gnt[1]),  128'(eg[b]));
      chk($sformatf("t2.%0d mode", b), 128'(mode[1]), 128'(em[b]));
      if (b == 3) req[1] = 3'b000;
      c = 0;
      nack = 0;
      while (busy[1] && c < 100) begin
        if (ack[1] != 3'b000) nack++;
        c++;
        tick();
      end
      chk($sformatf("t2.%0d len", b),  128'(c),    128'd29);
      chk($sformatf("t2.%0d acks", b), 128'(nack), 128'd1);
    end

    // T3: B drops request during d3 of its 3rd frame
    db[2]  = 8'h3C;
    req[2] = 3'b010;
    wait_gnt(2, "t3");
    chk("t3 gnt", 128'(gnt[2]), 128'h2);
    c = 0;
    nack = 0;
    f3 = '0;
    while (busy[2] && c < 200) begin
      if (ack[2][1]) nack++;
      if (c >= 39 && c <= 48) f3 = {f3[8:0], din[2]};
      if (c == 44) req[2] = 3'b000;
      c++;
      tick();
    end
    chk("t3 len",    128'(c),    128'd49);
    chk("t3 acks",   128'(nack), 128'd3);
    chk("t3 frame3", 128'(f3),   128'({1'b1, 8'h3C, 1'b0}));

    // T4: full 240-frame block from C, A also waiting
    dc[2]  = 8'd0;
    req[2] = 3'b101;
    wait_gnt(2, "t4");
    chk("t4 gnt",  128'(gnt[2]),  128'h4);
    chk("t4 mode", 128'(mode[2]), 128'h2);
    c = 0;
    nack = 0;
    bad = 0;
    fr = 0;
    w = '0;
    while (busy[2] && c < 3000) begin
      if (c >= 19) begin
        w = {w[8:0], din[2]};
        if ((c - 19) % 10 == 9) begin
          if (w !== {1'b1, 8'(fr), 1'b0}) bad++;
          fr++;
        end
      end
      if (ack[2][2]) begin
        nack++;
        dc[2] = dc[2] + 8'd1;
      end
      c++;
      tick();
    end
    chk("t4 len",    128'(c),    128'd2419);
    chk("t4 acks",   128'(nack), 128'd240);
    chk("t4 frames", 128'(fr),   128'd240);
    chk("t4 data",   128'(bad),  128'd0);
    wait_gnt(2, "t4 next");
    chk("t4 next gnt",  128'(gnt[2]),  128'h1);
    chk("t4 next mode", 128'(mode[2]), 128'h0);
    req[2] = 3'b000;
    wait_idle(2, "t4");

    // T5: BIT_DIV=4, single frame from C
    dc[3]  = 8'h81;
    req[3] = 3'b100;
    wait_gnt(3, "t5");
    chk("t5 mode", 128'(mode[3]), 128'h2);
    req[3] = 3'b000;
    b29 = {10'b0, 9'h1FF, 1'b1, 8'h81, 1'b0};
    e116 = '0;
    for (int i = 0; i < 29; i++)
      for (int j = 0; j < 4; j++)
        e116 = {e116[114:0], b29[28-i]};
    g116 = '0;
    c = 0;
    first = -1;
    while (busy[3] && c < 300) begin
      g116 = {g116[114:0], din[3]};
      if (ack[3] != 3'b000 && first < 0) first = c;
      c++;
      tick();
    end
    chk("t5 len",    128'(c),     128'd116);
    chk("t5 ack at", 128'(first), 128'd76);
    chk("t5 stream", 128'(g116),  128'(e116));

    // T6: async reset mid-frame, then restart on B
    db[0]  = 8'hFF;
    req[0] = 3'b010;
    wait_gnt(0, "t6");
    chk("t6 mode", 128'(mode[0]), 128'h1);
    for (int k = 0; k < 22; k++) tick();
    chk("t6 din mid", 128'(din[0]), 128'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6 rst din",  128'(din[0]),  128'd0);
    chk("t6 rst mode", 128'(mode[0]), 128'd0);
    chk("t6 rst gnt",  128'(gnt[0]),  128'd0);
    chk("t6 rst busy", 128'(busy[0]), 128'd0);
    chk("t6 rst ack",  128'(ack[0]),  128'd0);
    tick();
    tick();
    rstn = 1'b1;
    wait_gnt(0, "t6 restart");
    chk("t6 re gnt",  128'(gnt[0]),  128'h2);
    chk("t6 re mode", 128'(mode[0]), 128'h1);
    g20 = '0;
    ack_pre = '0;
    for (int k = 0; k < 20; k++) begin
      g20 = {g20[18:0], din[0]};
      if (k < 19) ack_pre = ack_pre | ack[0];
      else chk("t6 first ack", 128'(ack[0]), 128'h2);
      tick();
    end
    chk("t6 no early ack", 128'(ack_pre), 128'd0);
    chk("t6 sync hdr", 128'(g20), 128'({10'b0, 9'h1FF, 1'b1}));
    req[0] = 3'b000;
    wait_idle(0, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/din_link_scheduler.md
# din_link_scheduler

Serial-link scheduler that shares the single DIN line of the data converter among three byte sources and configures the converter's MODE for the active source. Per grant it emits a sync header (run of zeros, then run of ones), then a burst of 10-bit frames (start 1, 8 data bits MSB first, stop 0) drawn from the granted source. It runs in the CLK_30MHZ domain, drives DIN and MODE directly, and uses round-robin arbitration.

## Interface
- BLOCK_LEN, 240, max frames per grant (1..1023)
- SYNC_ZEROS, 10, zero bits in sync header (1..63)
- SYNC_ONES, 9, one bits in sync header (1..63)
- BIT_DIV, 1, clocks per serial bit (1..16)
- CLK_30MHZ  in  1  sole clock, rising edge
- RSTN  in  1  asynchronous, active-low reset
- REQ  in  3  per-source request, level; bit0=A, bit1=B, bit2=C
- DATA_A / DATA_B / DATA_C  in  8  byte of each source, held stable while its REQ is high and until its ACK
- ACK  out  3  one-clock pulse: byte of that source consumed
- GNT  out  3  one-hot grant, held for the whole block
- MODE  out  2  converter mode: 00=A, 01=B, 10=C; 11 never driven
- DIN  out  1  serial line to converter
- BUSY  out  1  high in any state except IDLE

## Operation
- States: IDLE, SYNC0, SYNC1, FRAME.
- IDLE: DIN=0, GNT=0. If REQ≠0, pick the first requester at or after priority pointer PTR (mod 3); on that edge set GNT, MODE=index, FCNT=0 and go to SYNC0.
- SYNC0: DIN=0 for SYNC_ZEROS bits, then SYNC1.
- SYNC1: DIN=1 for SYNC_ONES bits, then FRAME.
- FRAME: on entry, load shift register from DATA of granted source, pulse ACK[g]. Bits sent: 1, d7..d0, 0 (10 bits). In the last clock of the stop bit, FCNT+1 is evaluated:
  - if FCNT+1 == BLOCK_LEN or REQ[g]==0, go to IDLE, clear GNT, and set PTR = (g+1) mod 3.
  - otherwise reload, pulse ACK[g], and begin the next start bit on the following clock with no gap.
- REQ[g] dropping mid-frame does not truncate the frame. The current frame completes, and the exit is taken at its stop bit.
- REQ of non-granted sources is ignored until IDLE.
- MODE holds its value after the block ends. It changes only at a new grant, and always before any sync bit for that grant.
- Reset values: DIN=0, MODE=00, ACK=000, GNT=000, BUSY=0, PTR=0, FCNT=0, state IDLE.
- Reset asserted mid-block aborts immediately: the partial frame is discarded and no ACK is issued.

## Timing
- Bit timing: each serial bit lasts BIT_DIV clocks. A divider counter is restarted on every state entry.
- Grant edge: the registered outputs GNT, MODE and BUSY rise one clock after REQ is sampled high in IDLE. The first SYNC0 bit starts in the same clock.
- First start bit begins (SYNC_ZEROS+SYNC_ONES)×BIT_DIV clocks after the grant edge, i.e. 19 clocks with defaults.
- ACK[g] is high during the first clock of each start bit. The source may present its next byte from the following clock.
- Frame period is 10×BIT_DIV clocks. Back-to-back frames are contiguous.
- Block exit: BUSY falls on the clock after the last stop-bit clock. A new grant may occur on the next clock after that (one IDLE clock minimum, DIN=0).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state enum (IDLE/SYNC0/SYNC1/FRAME);
  - MODE codes MODE_A/B/C;
  - the FRAME_BITS=10 constant;
  - the start/stop bit values.
- Sub-module din_frame_serializer holds the 10-bit shift register, bit counter, BIT_DIV divider and a done strobe. The top level holds the FSM, arbiter, FCNT, PTR and ACK/GNT/MODE.

## Test plan
- Reset then REQ=001 with DATA_A=8'hA5, BLOCK_LEN=2 -> MODE=00; DIN = 10 zeros, 9 ones, then 1 1010_0101 0 twice; 2 ACK[0] pulses; BUSY falls 39 clocks after the grant edge.
- REQ=111 held, BLOCK_LEN=1 -> grants in order A, B, C, A; MODE 00, 01, 10, 00; each block is one sync header plus one frame.
- REQ[1] dropped during bit d3 of its 3rd frame, BLOCK_LEN=240 -> the 3rd frame completes with its stop bit, then IDLE; exactly 3 ACK[1] pulses.
- BLOCK_LEN=240 with DATA_C incremented on each ACK from 0 -> 240 frames with data 0..239; FCNT exit after frame 240; PTR moves to A.
- BIT_DIV=4 -> every DIN bit is 4 clocks wide; first start bit 76 clocks after the grant edge.
- RSTN pulsed low mid-frame -> DIN=0, MODE=00, GNT=0 asynchronously; after release a new REQ=010 restarts with a full sync header.
